// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle MIPS main controller and its datapath.
// The controller drives the strobes (master); the datapath returns opcode,
// zero flag and memory handshake (slave).
interface mc_control_fsm_if #(
   parameter int unsigned CNT_W = 32
);
   logic [5:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic             pc_en;
   logic             iord;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic             mem_to_reg;
   logic             reg_dst;
   logic             reg_write;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic [1:0]       pc_source;
   logic             illegal_op;
   logic [CNT_W-1:0] retired;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
             reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, retired
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
             reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, retired
   );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: walks the shared-memory datapath through
// fetch/decode/execute/memory/writeback, stalls on mem_ready in memory states
// and counts retired instructions.
module mc_control_fsm #(
   parameter int unsigned CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   mc_control_fsm_if.master   bus
);

   localparam logic [5:0] OpR    = 6'b000000;
   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpSw   = 6'b101011;
   localparam logic [5:0] OpBeq  = 6'b000100;
   localparam logic [5:0] OpJ    = 6'b000010;
   localparam logic [5:0] OpAddi = 6'b001000;

   typedef enum logic [3:0] {
      StIdle,
      StFetch,
      StDecode,
      StMemAddr,
      StMemRd,
      StMemWr,
      StMemWb,
      StREx,
      StRWb,
      StAddiEx,
      StAddiWb,
      StBranch,
      StJump
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic       retire;
   logic       pc_write;
   logic       pc_write_cond;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal_op;

   // State and retired-counter registers; reset forces IDLE so all strobes drop at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   // Next-state, per-state control strobes and retire pulse.
   always_comb begin
      state_d       = state_q;
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;

      case (state_q)
         StIdle: begin
            state_d = StFetch;
         end
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            // IR and PC only load on the cycle the fetch actually returns data.
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end
         end
         StDecode: begin
            alu_src_b = 2'b11;
            case (bus.opcode)
               OpR:        state_d = StREx;
               OpLw, OpSw: state_d = StMemAddr;
               OpBeq:      state_d = StBranch;
               OpJ:        state_d = StJump;
               OpAddi:     state_d = StAddiEx;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = StFetch;
               end
            endcase
         end
         StMemAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (bus.opcode == OpSw) ? StMemWr : StMemRd;
         end
         StMemRd: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (bus.mem_ready) begin
               state_d = StMemWb;
            end
         end
         StMemWr: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (bus.mem_ready) begin
               state_d = StFetch;
               retire  = 1'b1;
            end
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = StFetch;
            retire     = 1'b1;
         end
         StREx: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = StRWb;
         end
         StRWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = StFetch;
            retire    = 1'b1;
         end
         StAddiEx: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = StAddiWb;
         end
         StAddiWb: begin
            reg_write = 1'b1;
            state_d   = StFetch;
            retire    = 1'b1;
         end
         StBranch: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_source     = 2'b01;
            pc_write_cond = 1'b1;
            state_d       = StFetch;
            retire        = 1'b1;
         end
         StJump: begin
            pc_source = 2'b10;
            pc_write  = 1'b1;
            state_d   = StFetch;
            retire    = 1'b1;
         end
         default: begin
            state_d = StFetch;
         end
      endcase

      retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
   end

   assign bus.pc_en      = pc_write | (pc_write_cond & bus.zero);
   assign bus.iord       = iord;
   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = mem_write;
   assign bus.ir_write   = ir_write;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.reg_dst    = reg_dst;
   assign bus.reg_write  = reg_write;
   assign bus.alu_src_a  = alu_src_a;
   assign bus.alu_src_b  = alu_src_b;
   assign bus.alu_op     = alu_op;
   assign bus.pc_source  = pc_source;
   assign bus.illegal_op = illegal_op;
   assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a cycle table covering the directed sequences,
// an asynchronous mid-instruction reset, then random instructions checked
// against per-instruction latency and strobe-count arithmetic.
module tb_mc_control_fsm;

   localparam int unsigned CNT_W = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   mc_control_fsm_if #(.CNT_W(CNT_W)) bus ();

   mc_control_fsm #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [5:0]  op;
      logic        z;
      logic        rdy;
      logic [15:0] exp;
      int unsigned ret;
   } vec_t;

   vec_t tbl[$];

   // Expected-output words, assembled from the per-state strobe lists.
   logic [15:0] w_idle, w_f_stall, w_f_rdy, w_dec, w_dec_ill, w_maddr, w_mrd, w_mwr, w_mwb;
   logic [15:0] w_rex, w_rwb, w_aex, w_awb, w_br_nt, w_br_t, w_jmp;

   function automatic logic [15:0] ow(input logic pc_en, input logic iord, input logic rd,
                                      input logic wr, input logic ir, input logic m2r,
                                      input logic dst, input logic rw, input logic a,
                                      input logic [1:0] b, input logic [1:0] op,
                                      input logic [1:0] src, input logic ill);
      return {pc_en, iord, rd, wr, ir, m2r, dst, rw, a, b, op, src, ill};
   endfunction

   function automatic logic [15:0] outs();
      return {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
              bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
              bus.pc_source, bus.illegal_op};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic z, input logic rdy);
      bus.opcode    = op;
      bus.zero      = z;
      bus.mem_ready = rdy;
   endtask

   // One clock: apply inputs just after the rising edge, sample on the falling edge.
   task automatic cyc(input logic [5:0] op, input logic z, input logic rdy);
      @(posedge clk);
      #1;
      drive(op, z, rdy);
      @(negedge clk);
   endtask

   task automatic add(input logic [5:0] op, input logic z, input logic rdy,
                      input logic [15:0] exp, input int unsigned ret);
      vec_t v;
      v.op  = op;
      v.z   = z;
      v.rdy = rdy;
      v.exp = exp;
      v.ret = ret;
      tbl.push_back(v);
   endtask

   function automatic logic [CNT_W-1:0] wrap(input int unsigned v);
      return CNT_W'(v % (1 << CNT_W));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0]  op;
      logic        z, rdy, is_mem, is_ill;
      int unsigned f, m, base, len, kind, model_ret;
      int          ir_cnt, ir_at, rd_cnt, wr_cnt, iord_cnt, rw_cnt, pc_cnt, ill_cnt;

      w_idle    = '0;
      w_f_stall = ow(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      w_f_rdy   = ow(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      w_dec     = ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
      w_dec_ill = ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1);
      w_maddr   = ow(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      w_mrd     = ow(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      w_mwr     = ow(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      w_mwb     = ow(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      w_rex     = ow(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
      w_rwb     = ow(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      w_aex     = ow(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      w_awb     = ow(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      w_br_nt   = ow(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
      w_br_t    = ow(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
      w_jmp     = ow(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);

      // R-type, mem_ready high (ignored in R_EX even when low)
      add(OP_R, 0, 1, w_f_rdy, 0);
      add(OP_R, 0, 1, w_dec, 0);
      add(OP_R, 0, 0, w_rex, 0);
      add(OP_R, 0, 1, w_rwb, 0);
      // LW with two stall cycles in MEM_RD: 7 cycles
      add(OP_LW, 0, 1, w_f_rdy, 1);
      add(OP_LW, 0, 1, w_dec, 1);
      add(OP_LW, 0, 1, w_maddr, 1);
      add(OP_LW, 0, 0, w_mrd, 1);
      add(OP_LW, 0, 0, w_mrd, 1);
      add(OP_LW, 0, 1, w_mrd, 1);
      add(OP_LW, 0, 1, w_mwb, 1);
      // BEQ taken, then not taken
      add(OP_BEQ, 1, 1, w_f_rdy, 2);
      add(OP_BEQ, 1, 0, w_dec, 2);
      add(OP_BEQ, 1, 1, w_br_t, 2);
      add(OP_BEQ, 0, 1, w_f_rdy, 3);
      add(OP_BEQ, 0, 1, w_dec, 3);
      add(OP_BEQ, 0, 1, w_br_nt, 3);
      // ADDI behind a three-cycle fetch stall
      add(OP_ADDI, 1, 0, w_f_stall, 4);
      add(OP_ADDI, 1, 0, w_f_stall, 4);
      add(OP_ADDI, 1, 0, w_f_stall, 4);
      add(OP_ADDI, 1, 1, w_f_rdy, 4);
      add(OP_ADDI, 1, 1, w_dec, 4);
      add(OP_ADDI, 1, 1, w_aex, 4);
      add(OP_ADDI, 1, 1, w_awb, 4);
      // Illegal opcode, then J
      add(OP_BAD, 0, 1, w_f_rdy, 5);
      add(OP_BAD, 0, 1, w_dec_ill, 5);
      add(OP_J, 0, 1, w_f_rdy, 5);
      add(OP_J, 0, 1, w_dec, 5);
      add(OP_J, 0, 1, w_jmp, 5);
      // SW stalled in MEM_WR, to be aborted by reset
      add(OP_SW, 0, 1, w_f_rdy, 6);
      add(OP_SW, 0, 1, w_dec, 6);
      add(OP_SW, 0, 1, w_maddr, 6);
      add(OP_SW, 0, 0, w_mwr, 6);
      add(OP_SW, 0, 0, w_mwr, 6);

      drive(OP_R, 1'b0, 1'b1);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset outputs", 32'(outs()), 32'(w_idle));
      chk("reset retired", 32'(bus.retired), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle outputs", 32'(outs()), 32'(w_idle));

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].op, tbl[i].z, tbl[i].rdy);
         chk($sformatf("row%0d outputs", i), 32'(outs()), 32'(tbl[i].exp));
         chk($sformatf("row%0d retired", i), 32'(bus.retired), 32'(wrap(tbl[i].ret)));
      end

      // Asynchronous abort during MEM_WR
      #2 rst_n = 1'b0;
      #1;
      chk("abort mem_write", 32'(bus.mem_write), 32'd0);
      chk("abort outputs", 32'(outs()), 32'(w_idle));
      chk("abort retired", 32'(bus.retired), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(OP_R, 1'b0, 1'b0);
      @(negedge clk);
      chk("post-abort idle", 32'(outs()), 32'(w_idle));
      cyc(OP_R, 1'b0, 1'b0);
      chk("post-abort fetch", 32'(outs()), 32'(w_f_stall));

      // Random instructions against latency / strobe-count arithmetic
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      model_ret = 0;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 6);
         case (kind)
            0: op = OP_R;
            1: op = OP_LW;
            2: op = OP_SW;
            3: op = OP_BEQ;
            4: op = OP_J;
            5: op = OP_ADDI;
            default: begin
               op = 6'($urandom);
               while (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
                      op == OP_J || op == OP_ADDI) op = 6'($urandom);
            end
         endcase
         z      = 1'($urandom);
         f      = $urandom_range(0, 3);
         is_mem = (op == OP_LW) || (op == OP_SW);
         is_ill = (kind == 6);
         m      = is_mem ? $urandom_range(0, 3) : 0;
         if (op == OP_LW) base = 5;
         else if (op == OP_SW || op == OP_R || op == OP_ADDI) base = 4;
         else if (op == OP_BEQ || op == OP_J) base = 3;
         else base = 2;
         len = base + f + m;
         ir_cnt = 0; ir_at = -1; rd_cnt = 0; wr_cnt = 0; iord_cnt = 0;
         rw_cnt = 0; pc_cnt = 0; ill_cnt = 0;
         for (int k = 0; k < int'(len); k++) begin
            if (k < int'(f)) rdy = 1'b0;
            else if (k == int'(f)) rdy = 1'b1;
            else if (is_mem && k >= int'(f + 3) && k < int'(f + 3 + m)) rdy = 1'b0;
            else if (is_mem && k == int'(f + 3 + m)) rdy = 1'b1;
            else rdy = 1'($urandom);
            cyc(op, z, rdy);
            if (k == 0) chk("rnd retired", 32'(bus.retired), 32'(wrap(model_ret)));
            if (bus.ir_write) begin
               ir_cnt++;
               ir_at = k;
            end
            rd_cnt   += int'(bus.mem_read);
            wr_cnt   += int'(bus.mem_write);
            iord_cnt += int'(bus.iord);
            rw_cnt   += int'(bus.reg_write);
            pc_cnt   += int'(bus.pc_en);
            ill_cnt  += int'(bus.illegal_op);
         end
         chk("rnd ir_write count", 32'(ir_cnt), 32'd1);
         chk("rnd ir_write cycle", 32'(ir_at), 32'(f));
         chk("rnd mem_read cycles", 32'(rd_cnt), 32'(f + 1 + ((op == OP_LW) ? m + 1 : 0)));
         chk("rnd mem_write cycles", 32'(wr_cnt), 32'((op == OP_SW) ? m + 1 : 0));
         chk("rnd iord cycles", 32'(iord_cnt), 32'(is_mem ? m + 1 : 0));
         chk("rnd reg_write cycles", 32'(rw_cnt),
             32'((op == OP_R || op == OP_ADDI || op == OP_LW) ? 1 : 0));
         chk("rnd pc_en cycles", 32'(pc_cnt),
             32'(1 + ((op == OP_J) ? 1 : 0) + ((op == OP_BEQ && z) ? 1 : 0)));
         chk("rnd illegal pulses", 32'(ill_cnt), 32'(is_ill ? 1 : 0));
         if (!is_ill) model_ret++;
      end
      cyc(OP_R, 1'b0, 1'b0);
      chk("rnd final retired", 32'(bus.retired), 32'(wrap(model_ret)));
      chk("rnd final fetch", 32'(outs()), 32'(w_f_stall));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
